// File: rtl/hatch_stage_ctrl.sv
// -----------------------------------------------------------------------------
// hatch_stage_ctrl
// Incubation sequencer that drives the 8x8 dot-matrix display driver with the
// current hatch stage (num), a display enable (st) and a temperature-alarm
// colour select (temp). Incubation time is counted on the 1 kHz system clock.
// The stage only advances while the measured temperature is in range. Start
// and pause keys control the run, and the sequence stops at the hatched stage.
//
// Optional feature (macro HATCH_OVERTEMP_ABORT_EN): abort to IDLE and raise a
// sticky fault after ABORT_TICKS consecutive out-of-range cycles while running
// or paused. Without the macro, fault is constant 0.
//
// Ports:
//   clk        in   1   1 kHz system clock
//   rst        in   1   synchronous active-high reset
//   start_key  in   1   debounced start key (level, active-high)
//   pause_key  in   1   debounced pause key (level, active-high)
//   temp_in    in   8   measured temperature, unsigned degrees C
//   num        out  4   current stage to display (0..LAST_STAGE)
//   st         out  1   display enable (running/paused/done)
//   temp       out  1   temperature out of range while st=1
//   done       out  1   hatched (stage LAST_STAGE reached)
//   fault      out  1   over-temperature abort flag (optional feature)
// -----------------------------------------------------------------------------
module hatch_stage_ctrl #(
    parameter int         TICKS_PER_STAGE = 1000,
    parameter int         LAST_STAGE      = 11,
    parameter logic [7:0] TEMP_LO         = 8'd37,
    parameter logic [7:0] TEMP_HI         = 8'd39,
    parameter int         ABORT_TICKS     = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_key,
    input  logic       pause_key,
    input  logic [7:0] temp_in,
    output logic [3:0] num,
    output logic       st,
    output logic       temp,
    output logic       done,
    output logic       fault
);

    localparam int             CW       = $clog2(TICKS_PER_STAGE);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(TICKS_PER_STAGE - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [3:0]     LAST_NUM = 4'(LAST_STAGE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    num_q, num_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fault_q, fault_d;
    logic          st_q, st_d;
    logic          temp_q, temp_d;
    logic          done_q, done_d;

    // Key edges are registered once more so an edge seen at edge N acts at N+1.
    logic          start_key_q, pause_key_q;
    logic          start_edge_q, pause_edge_q;

    logic          temp_ok_s;

`ifdef HATCH_OVERTEMP_ABORT_EN
    logic [15:0]   abort_q, abort_d;
`endif

    assign temp_ok_s = (temp_in >= TEMP_LO) && (temp_in <= TEMP_HI);

    // State, counters, key edge pipeline and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            num_q        <= 4'd0;
            cnt_q        <= '0;
            fault_q      <= 1'b0;
            st_q         <= 1'b0;
            temp_q       <= 1'b0;
            done_q       <= 1'b0;
            start_key_q  <= 1'b0;
            pause_key_q  <= 1'b0;
            start_edge_q <= 1'b0;
            pause_edge_q <= 1'b0;
`ifdef HATCH_OVERTEMP_ABORT_EN
            abort_q      <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            cnt_q        <= cnt_d;
            fault_q      <= fault_d;
            st_q         <= st_d;
            temp_q       <= temp_d;
            done_q       <= done_d;
            start_key_q  <= start_key;
            pause_key_q  <= pause_key;
            start_edge_q <= start_key & ~start_key_q;
            pause_edge_q <= pause_key & ~pause_key_q;
`ifdef HATCH_OVERTEMP_ABORT_EN
            abort_q      <= abort_d;
`endif
        end
    end

    // Next-state logic: stage progression, pause handling and optional abort.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: begin
                num_d = 4'd0;
                cnt_d = '0;
                if (start_edge_q) begin
                    state_d = S_RUN;
                    fault_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // Pause wins over a progress tick; out-of-range freezes the count.
                if (pause_edge_q) begin
                    state_d = S_PAUSE;
                end else if (temp_ok_s) begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_d = '0;
                        num_d = num_q + 4'd1;
                        if (num_d == LAST_NUM) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RUN;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_PAUSE: begin
                if (pause_edge_q) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_PAUSE;
                end
            end
            S_DONE: begin
                cnt_d = '0;
                if (start_edge_q) begin
                    state_d = S_RUN;
                    num_d   = 4'd0;
                end else begin
                    num_d   = LAST_NUM;
                end
            end
            default: begin
                state_d = S_IDLE;
                num_d   = 4'd0;
                cnt_d   = '0;
            end
        endcase

`ifdef HATCH_OVERTEMP_ABORT_EN
        // Consecutive out-of-range cycles while active; reaching the limit aborts.
        abort_d = 16'd0;
        if (((state_q == S_RUN) || (state_q == S_PAUSE)) && !temp_ok_s) begin
            abort_d = abort_q + 16'd1;
            if (abort_d == 16'(ABORT_TICKS)) begin
                state_d = S_IDLE;
                num_d   = 4'd0;
                cnt_d   = '0;
                fault_d = 1'b1;
                abort_d = 16'd0;
            end else begin
                fault_d = fault_q;
            end
        end else begin
            abort_d = 16'd0;
        end
`else
        fault_d = 1'b0;
`endif
    end

    // Output decode from the next state so outputs are registered with it.
    always_comb begin
        st_d   = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        temp_d = st_d & ~temp_ok_s;
    end

    assign num   = num_q;
    assign st    = st_q;
    assign temp  = temp_q;
    assign done  = done_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_hatch_stage_ctrl.sv
module tb_hatch_stage_ctrl;

    localparam int T  = 4;
    localparam int L  = 11;
    localparam int AB = 8;
`ifdef HATCH_OVERTEMP_ABORT_EN
    localparam int FREEZE_N = AB - 1;
`else
    localparam int FREEZE_N = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start_key;
    logic       pause_key;
    logic [7:0] temp_in;
    logic [3:0] num;
    logic       st;
    logic       temp;
    logic       done;
    logic       fault;

    wire  [7:0] obs_s = {num, st, temp, done, fault};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase 0 idle, 1 running, 2 paused, 3 hatched.
    // Progress is total in-range running cycles; the stage is derived from it.
    int m_phase;
    int m_elapsed;
    int m_bad_run;
    bit m_fault;
    bit m_temp;
    bit m_prev_s, m_prev_p, m_pend_s, m_pend_p;

    hatch_stage_ctrl #(
        .TICKS_PER_STAGE(T),
        .LAST_STAGE     (L),
        .TEMP_LO        (8'd37),
        .TEMP_HI        (8'd39),
        .ABORT_TICKS    (AB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_key(start_key),
        .pause_key(pause_key),
        .temp_in  (temp_in),
        .num      (num),
        .st       (st),
        .temp     (temp),
        .done     (done),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_vec();
        int stage;
        stage = m_elapsed / T;
        if (stage > L) stage = L;
        return {4'(stage), (m_phase != 0), m_temp, (m_phase == 3), m_fault};
    endfunction

    // One clock: the model consumes the inputs seen at the edge, then outputs settle.
    task automatic tick();
        bit ok;
        bit aborted;
        @(posedge clk);
        ok = (temp_in >= 8'd37) && (temp_in <= 8'd39);
        aborted = 1'b0;
        if (rst) begin
            m_phase = 0; m_elapsed = 0; m_bad_run = 0; m_fault = 1'b0; m_temp = 1'b0;
            m_prev_s = 1'b0; m_prev_p = 1'b0; m_pend_s = 1'b0; m_pend_p = 1'b0;
        end else begin
`ifdef HATCH_OVERTEMP_ABORT_EN
            if ((m_phase == 1 || m_phase == 2) && !ok) begin
                m_bad_run++;
                if (m_bad_run == AB) begin
                    m_phase = 0; m_elapsed = 0; m_fault = 1'b1; m_bad_run = 0;
                    aborted = 1'b1;
                end
            end else begin
                m_bad_run = 0;
            end
`endif
            if (!aborted) begin
                if (m_phase == 0 || m_phase == 3) begin
                    if (m_pend_s) begin
                        m_phase = 1; m_elapsed = 0; m_fault = 1'b0;
                    end
                end else if (m_phase == 1) begin
                    if (m_pend_p) m_phase = 2;
                    else if (ok) begin
                        m_elapsed++;
                        if (m_elapsed == L * T) m_phase = 3;
                    end
                end else if (m_pend_p) begin
                    m_phase = 1;
                end
            end
            m_temp   = (m_phase != 0) && !ok;
            m_pend_s = start_key && !m_prev_s;
            m_pend_p = pause_key && !m_prev_p;
            m_prev_s = start_key;
            m_prev_p = pause_key;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_key = 1'b0; pause_key = 1'b0; temp_in = 8'd38;
        tick(); tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (obs_s !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b, want 00000000", obs_s);
        end
        n_cmp++;
        if (obs_s !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_model: got %b, want %b", obs_s, exp_vec());
        end
    endtask

    task automatic test_stage_progress();
        int seen;
        seen = 0;
        start_key = 1'b1;
        tick();
        start_key = 1'b0;
        n_cmp++;
        if (st !== 1'b0) begin
            n_bad++;
            $display("FAIL start_latency1: st got %b, want 0", st);
        end
        tick();
        n_cmp++;
        if (st !== 1'b1 || num !== 4'd0) begin
            n_bad++;
            $display("FAIL start_latency2: st/num got %b/%0d, want 1/0", st, num);
        end
        for (int i = 1; i <= 60; i++) begin
            tick();
            n_cmp++;
            if (obs_s !== exp_vec()) begin
                n_bad++;
                $display("FAIL progress_cycle%0d: got %b, want %b", i, obs_s, exp_vec());
            end
            if (done === 1'b1 && seen == 0) seen = i;
            if (seen != 0) break;
        end
        n_cmp++;
        if (seen != L * T || num !== 4'(L)) begin
            n_bad++;
            $display("FAIL done_timing: done at cycle %0d num %0d, want cycle %0d num %0d", seen, num, L * T, L);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (num !== 4'(L) || done !== 1'b1 || st !== 1'b1) begin
                n_bad++;
                $display("FAIL done_hold%0d: num/done/st got %0d/%b/%b, want %0d/1/1", i, num, done, st, L);
            end
        end
    endtask

    // Runs until the model reaches the given progress while running; bounded.
    task automatic run_until(input int target, input string nm);
        int k;
        k = 0;
        while (!(m_phase == 1 && m_elapsed == target) && k < 200) begin
            tick();
            k++;
            n_cmp++;
            if (obs_s !== exp_vec()) begin
                n_bad++;
                $display("FAIL %s_track: got %b, want %b", nm, obs_s, exp_vec());
            end
        end
        if (k >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: progress %0d, want %0d", nm, m_elapsed, target);
        end
    endtask

    task automatic test_temp_freeze();
        start_key = 1'b1; tick(); start_key = 1'b0;
        run_until(3 * T + 2, "freeze");
        temp_in = 8'd45;
        for (int i = 0; i < FREEZE_N; i++) begin
            tick();
            n_cmp++;
            if (num !== 4'd3 || temp !== 1'b1 || st !== 1'b1) begin
                n_bad++;
                $display("FAIL freeze_hold%0d: num/temp/st got %0d/%b/%b, want 3/1/1", i, num, temp, st);
            end
        end
        temp_in = 8'd38;
        tick();
        n_cmp++;
        if (num !== 4'd3 || temp !== 1'b0) begin
            n_bad++;
            $display("FAIL freeze_resume1: num/temp got %0d/%b, want 3/0", num, temp);
        end
        tick();
        n_cmp++;
        if (num !== 4'd4) begin
            n_bad++;
            $display("FAIL freeze_resume2: num got %0d, want 4", num);
        end
    endtask

    task automatic test_pause();
        run_until(5 * T, "pause");
        start_key = 1'b1;
        pause_key = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (i == 0) pause_key = 1'b0;
            n_cmp++;
            if (num !== 4'd5 || st !== 1'b1) begin
                n_bad++;
                $display("FAIL pause_hold%0d: num/st got %0d/%b, want 5/1", i, num, st);
            end
        end
        pause_key = 1'b1;
        tick();
        pause_key = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (num !== 4'd6 || obs_s !== exp_vec()) begin
            n_bad++;
            $display("FAIL pause_resume: got %b num %0d, want %b num 6", obs_s, num, exp_vec());
        end
        start_key = 1'b0;
        tick();
    endtask

    task automatic test_reset_midrun();
        run_until(7 * T, "midrst");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (num !== 4'd0 || st !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_reset: num/st/done got %0d/%b/%b, want 0/0/0", num, st, done);
        end
        tick(); tick();
        n_cmp++;
        if (st !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_idle: st got %b, want 0", st);
        end
        start_key = 1'b1; tick(); start_key = 1'b0; tick();
        n_cmp++;
        if (st !== 1'b1 || num !== 4'd0) begin
            n_bad++;
            $display("FAIL midrun_restart: st/num got %b/%0d, want 1/0", st, num);
        end
        for (int i = 0; i < T; i++) tick();
        n_cmp++;
        if (num !== 4'd1) begin
            n_bad++;
            $display("FAIL midrun_first_stage: num got %0d, want 1", num);
        end
    endtask

`ifdef HATCH_OVERTEMP_ABORT_EN
    task automatic test_abort();
        temp_in = 8'd30;
        for (int i = 1; i <= AB; i++) begin
            tick();
            n_cmp++;
            if (i < AB && (st !== 1'b1 || fault !== 1'b0)) begin
                n_bad++;
                $display("FAIL abort_early%0d: st/fault got %b/%b, want 1/0", i, st, fault);
            end else if (i == AB && (st !== 1'b0 || num !== 4'd0 || fault !== 1'b1)) begin
                n_bad++;
                $display("FAIL abort_trip: st/num/fault got %b/%0d/%b, want 0/0/1", st, num, fault);
            end
        end
        temp_in = 8'd38;
        tick(); tick();
        n_cmp++;
        if (fault !== 1'b1 || st !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_sticky: fault/st got %b/%b, want 1/0", fault, st);
        end
        start_key = 1'b1; tick(); start_key = 1'b0; tick();
        n_cmp++;
        if (fault !== 1'b0 || st !== 1'b1 || num !== 4'd0) begin
            n_bad++;
            $display("FAIL abort_restart: fault/st/num got %b/%b/%0d, want 0/1/0", fault, st, num);
        end
    endtask
`else
    task automatic test_no_abort();
        int frozen;
        frozen = m_elapsed / T;
        temp_in = 8'd30;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_cmp++;
            if (fault !== 1'b0 || st !== 1'b1 || num !== 4'(frozen) || temp !== 1'b1) begin
                n_bad++;
                $display("FAIL no_abort%0d: fault/st/num/temp got %b/%b/%0d/%b, want 0/1/%0d/1", i, fault, st, num, temp, frozen);
            end
        end
        temp_in = 8'd38;
        tick();
    endtask
`endif

    task automatic test_random();
        logic [7:0] temps [9];
        temps = '{8'd37, 8'd38, 8'd39, 8'd38, 8'd36, 8'd40, 8'd0, 8'd255, 8'd45};
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) temp_in = temps[$urandom_range(0, 8)];
            if ($urandom_range(0, 39) == 0) start_key = ~start_key;
            if ($urandom_range(0, 29) == 0) pause_key = ~pause_key;
            rst = ($urandom_range(0, 399) == 0);
            tick();
            n_cmp++;
            if (obs_s !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_cycle%0d: got %b, want %b", i, obs_s, exp_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        m_phase = 0; m_elapsed = 0; m_bad_run = 0; m_fault = 1'b0; m_temp = 1'b0;
        m_prev_s = 1'b0; m_prev_p = 1'b0; m_pend_s = 1'b0; m_pend_p = 1'b0;
        test_reset();
        test_stage_progress();
        test_temp_freeze();
        test_pause();
        test_reset_midrun();
`ifdef HATCH_OVERTEMP_ABORT_EN
        test_abort();
`else
        test_no_abort();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
